imm_extend_stage: RTL and testbench
===================================

Name: imm_extend_stage

Overview:
- Parametrised, registered immediate-extension stage for the instruction-decode pipeline.
- Extends an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper-load and branch-offset.
- Carries a sideband tag through a 2-entry skid buffer with valid/ready handshakes and flush.
- Decouples decode from the ID/EX register so that stalls do not create combinational ready paths.

Parameters:
IN_W, 16, immediate input width
OUT_W, 32, extended output width; OUT_W >= IN_W+2 is required (elaboration-time check)
TAG_W, 8, sideband tag width (dest reg / PC index), passed through unchanged

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  reset, synchronous, active-low
flush  in  1  synchronous pipeline flush; discards all buffered entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry; driven straight from a register
in_imm  in  IN_W  raw immediate field
in_mode  in  2  extension mode: 00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH
in_tag  in  TAG_W  sideband tag
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts the entry
out_imm  out  OUT_W  extended immediate
out_mode  out  2  mode the entry was extended with
out_tag  out  TAG_W  tag of the output entry

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, out_imm=0, out_mode=0, out_tag=0.
  - Skid register is cleared.
  - in_ready=1.
- Extension is combinational on the input side; the result is captured into the buffer, so the valid result appears on out_* the cycle after acceptance.
  - SIGN: {(OUT_W-IN_W){imm[IN_W-1]}, imm}
  - ZERO: {(OUT_W-IN_W){0}, imm}
  - UPPER: {imm, (OUT_W-IN_W){0}}
  - BRANCH: SIGN result shifted left by 2, truncated to OUT_W (the two MSBs of the sign-extended value are dropped).
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - out_* stay stable while out_valid && !out_ready.
- Buffer state machine (main register = out_*, plus one skid register):
  - EMPTY: input transfer -> ONE (main loaded).
  - ONE:
    - input transfer with no output transfer -> TWO (skid loaded, in_ready=0 next cycle);
    - input and output transfer together -> ONE (main reloaded with the new entry);
    - output transfer only -> EMPTY.
  - TWO: in_ready=0; output transfer -> ONE (skid moves into main, in_ready=1 next cycle).
- in_ready = !skid_valid, registered. No combinational path from out_ready to in_ready.
- Ordering is strict FIFO. Latency is 1 cycle when empty; throughput is 1 entry per cycle while out_ready=1.
- flush=1 at an edge:
  - Both entries are invalidated, state -> EMPTY, in_ready=1 next cycle.
  - A simultaneous input transfer is dropped; flush has priority.
  - Data registers may keep stale values; only the valids are cleared.
- rst_n=0 has priority over flush and over any handshake. Reset in the middle of a stall returns to EMPTY; in-flight entries are lost.
- When in_valid=0 or in_ready=0, in_mode/in_imm are don't-care and must not affect any state.

Decomposition:
- Shared package imm_ext_pkg holds:
  - the mode encodings IMM_SIGN/IMM_ZERO/IMM_UPPER/IMM_BRANCH as 2-bit constants;
  - a pure function imm_extend(imm, mode) parametrised on IN_W/OUT_W, reused by the decode and branch-target logic.
- One natural sub-module: skid_buffer (width = OUT_W+2+TAG_W, 2 entries, flush). It is generic and reusable for the other pipeline registers.
- The top level instantiates skid_buffer and applies imm_extend on its input side.

Test Plan:
- Reset then single accept: imm=16'h8004, mode SIGN, tag 8'h11, out_ready=1 -> next cycle out_valid=1, out_imm=32'hFFFF8004, out_tag=8'h11; the cycle after, out_valid=0.
- Mode sweep on imm=16'hFFFE:
  - ZERO -> 32'h0000FFFE
  - UPPER -> 32'hFFFE0000
  - BRANCH -> 32'hFFFFFFF8
  - BRANCH with imm=16'h7FFF -> 32'h0001FFFC
- Backpressure: out_ready=0, present 3 back-to-back entries (tags 1, 2, 3):
  - tags 1 and 2 are accepted; in_ready=0 from the cycle after tag 2; tag 3 is held upstream;
  - out_imm/out_tag stay at tag 1 unchanged;
  - release out_ready -> tags 1, 2, 3 are delivered in order, with no loss or duplicates.
- Streaming: in_valid=1 and out_ready=1 for 100 random entries -> 1 output per cycle after 1-cycle latency; every result matches the reference function.
- Flush in TWO state, with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the dropped entry never appears.
- rst_n=0 for one cycle while in TWO with out_ready=0 -> next cycle out_valid=0, in_ready=1, out_imm=0; a new entry is then accepted normally.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared definitions for immediate extension: mode encodings, buffer states and
// the width-generic extension function used by decode and branch-target logic.
package imm_ext_pkg;

  localparam logic [1:0] IMM_SIGN   = 2'b00;
  localparam logic [1:0] IMM_ZERO   = 2'b01;
  localparam logic [1:0] IMM_UPPER  = 2'b10;
  localparam logic [1:0] IMM_BRANCH = 2'b11;

  // Widest immediate/result the helper function can handle.
  localparam int unsigned ImmMaxW = 64;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } buf_state_e;

  // Extends the low in_w bits of imm to out_w bits; bits above out_w are zero.
  // Widths are passed as arguments so callers with any IN_W/OUT_W share it.
  function automatic logic [ImmMaxW-1:0] imm_extend(input logic [ImmMaxW-1:0] imm,
                                                   input logic [1:0]         mode,
                                                   input int unsigned        in_w,
                                                   input int unsigned        out_w);
    logic [ImmMaxW-1:0] in_mask;
    logic [ImmMaxW-1:0] out_mask;
    logic [ImmMaxW-1:0] zext;
    logic [ImmMaxW-1:0] sext;
    logic [ImmMaxW-1:0] res;
    logic               sign;
    // A shift by ImmMaxW yields 0, so the masks stay correct at full width.
    in_mask  = (ImmMaxW'(1) << in_w) - ImmMaxW'(1);
    out_mask = (ImmMaxW'(1) << out_w) - ImmMaxW'(1);
    zext     = imm & in_mask;
    sign     = |(zext & (ImmMaxW'(1) << (in_w - 1)));
    sext     = sign ? (zext | ~in_mask) : zext;
    unique case (mode)
      IMM_SIGN:   res = sext;
      IMM_ZERO:   res = zext;
      IMM_UPPER:  res = zext << (out_w - in_w);
      IMM_BRANCH: res = sext << 2;
      default:    res = sext;
    endcase
    return res & out_mask;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry skid buffer with valid/ready handshakes and flush.
// in_ready comes straight from a flop, so there is no out_ready -> in_ready path.
module skid_buffer
  import imm_ext_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  buf_state_e       state_q, state_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign in_ready  = ready_q;
  assign in_xfer   = in_valid & ready_q;
  assign out_xfer  = out_valid & out_ready;

  // Next-state and data movement between input, skid and main registers.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = StTwo;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush only drops the valids; data registers may hold stale entries.
    if (flush) begin
      state_d = StEmpty;
    end
    ready_d = (state_d != StTwo);
  end

  // State, data and registered ready with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage: extends on the input side and carries
// {imm, mode, tag} through a 2-entry skid buffer towards the ID/EX register.
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [1:0]       out_mode,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned DataW = OUT_W + 2 + TAG_W;

  if (OUT_W < IN_W + 2 || OUT_W > ImmMaxW) begin : g_bad_width
    $error("imm_extend_stage: need IN_W+2 <= OUT_W <= %0d", ImmMaxW);
  end

  logic [OUT_W-1:0] ext_imm;
  logic [DataW-1:0] in_data;
  logic [DataW-1:0] out_data;

  // Extension happens before the buffer so the stored entry is already final.
  assign ext_imm = OUT_W'(imm_extend(ImmMaxW'(in_imm), in_mode, IN_W, OUT_W));
  assign in_data = {ext_imm, in_mode, in_tag};

  skid_buffer #(
    .Width(DataW)
  ) u_skid_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  assign {out_imm, out_mode, out_tag} = out_data;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage with a queue-based FIFO model.
module tb_imm_extend_stage;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned TAG_W = 8;

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  mode;
    logic [7:0]  tag;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic [1:0]       out_mode;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  entry_t model_q[$];
  bit     model_live = 0;
  bit     data_zero  = 0;
  bit     count_outs = 0;
  int     stream_outs = 0;

  imm_extend_stage #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .TAG_W(TAG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm  (out_imm),
    .out_mode (out_mode),
    .out_tag  (out_tag)
  );

  initial forever #5 clk = ~clk;

  // Reference extension written as plain integer arithmetic.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    int s;
    s = $signed(imm);
    case (mode)
      2'd0:    return s;
      2'd1:    return {16'h0000, imm};
      2'd2:    return imm * 32'd65536;
      default: return s * 4;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of capacity 2 whose ready is simply "fewer than 2 held".
  always @(posedge clk) begin
    entry_t e;
    bit     ixf;
    bit     oxf;
    if (!rst_n) begin
      model_q.delete();
      model_live = 1;
      data_zero  = 1;
    end else if (model_live) begin
      ixf = in_valid && (model_q.size() < 2);
      oxf = (model_q.size() > 0) && out_ready;
      if (flush) begin
        model_q.delete();
      end else begin
        if (oxf) begin
          void'(model_q.pop_front());
          if (count_outs) stream_outs++;
        end
        if (ixf) begin
          e.imm  = ref_ext(in_imm, in_mode);
          e.mode = in_mode;
          e.tag  = in_tag;
          model_q.push_back(e);
          data_zero = 0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_live && rst_n) begin
      check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        check("out_imm", 64'(out_imm), 64'(model_q[0].imm));
        check("out_mode", 64'(out_mode), 64'(model_q[0].mode));
        check("out_tag", 64'(out_tag), 64'(model_q[0].tag));
      end else if (data_zero) begin
        check("idle_imm_zero", 64'(out_imm), 64'd0);
        check("idle_tag_zero", 64'(out_tag), 64'd0);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] imm, input logic [1:0] mode, input logic [7:0] tag);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
  endtask

  initial begin
    logic [15:0] sweep_imm  [4];
    logic [1:0]  sweep_mode [4];
    logic [31:0] sweep_exp  [4];
    sweep_imm  = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'h7FFF};
    sweep_mode = '{2'd1, 2'd2, 2'd3, 2'd3};
    sweep_exp  = '{32'h0000FFFE, 32'hFFFE0000, 32'hFFFFFFF8, 32'h0001FFFC};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_imm = '0; in_mode = '0; in_tag = '0;
    cycle(); cycle();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Single accept with 1-cycle latency.
    drive(16'h8004, 2'd0, 8'h11);
    cycle();
    in_valid = 1'b0;
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_imm", 64'(out_imm), 64'hFFFF8004);
    check("single_tag", 64'(out_tag), 64'h11);
    cycle();
    check("single_drain", 64'(out_valid), 64'd0);

    // Mode sweep.
    for (int i = 0; i < 4; i++) begin
      drive(sweep_imm[i], sweep_mode[i], 8'(i + 8'h20));
      cycle();
      in_valid = 1'b0;
      check("sweep_imm", 64'(out_imm), 64'(sweep_exp[i]));
      check("sweep_mode", 64'(out_mode), 64'(sweep_mode[i]));
      cycle();
    end

    // Backpressure: tags 1 and 2 accepted, tag 3 held upstream.
    out_ready = 1'b0;
    drive(16'h0001, 2'd0, 8'd1);
    cycle();
    drive(16'h0002, 2'd1, 8'd2);
    cycle();
    drive(16'h0003, 2'd2, 8'd3);
    check("bp_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold_tag", 64'(out_tag), 64'd1);
      check("bp_hold_imm", 64'(out_imm), 64'h00000001);
      check("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_tag2", 64'(out_tag), 64'd2);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
    check("bp_tag3", 64'(out_tag), 64'd3);
    check("bp_tag3_imm", 64'(out_imm), 64'h00030000);
    cycle();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Streaming: 100 random entries back to back.
    count_outs = 1;
    for (int i = 0; i < 100; i++) begin
      drive(16'($urandom), 2'($urandom), 8'($urandom));
      cycle();
      check("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    cycle(); cycle();
    count_outs = 0;
    check("stream_count", 64'(stream_outs), 64'd100);

    // Flush while TWO with a simultaneous input.
    out_ready = 1'b0;
    drive(16'h1111, 2'd0, 8'hA1);
    cycle();
    drive(16'h2222, 2'd0, 8'hA2);
    cycle();
    drive(16'h3333, 2'd0, 8'hA3);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("flush_no_ghost", 64'(out_valid), 64'd0);
    end

    // Reset while stalled in TWO.
    out_ready = 1'b0;
    drive(16'h4444, 2'd1, 8'hB1);
    cycle();
    drive(16'h5555, 2'd1, 8'hB2);
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_ready", 64'(in_ready), 64'd1);
    check("mrst_imm", 64'(out_imm), 64'd0);
    out_ready = 1'b1;
    drive(16'hFFFF, 2'd1, 8'hC3);
    cycle();
    in_valid = 1'b0;
    check("mrst_new_imm", 64'(out_imm), 64'h0000FFFF);
    check("mrst_new_tag", 64'(out_tag), 64'hC3);
    cycle();

    // Random traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cycle(); cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
